// File: rtl/network_pkg.sv
// Shared constants and types for the SNN network core and its downstream
// classification stage.
package network_pkg;

  // Number of output neurons, one per digit class.
  localparam int OUTPUT_SIZE     = 10;
  localparam int CLASS_IDX_WIDTH = $clog2(OUTPUT_SIZE);

  // Default widths of the classifier window/step counter and spike counters.
  localparam int DEFAULT_WINDOW_WIDTH = 8;
  localparam int DEFAULT_COUNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    ARGMAX,
    DONE
  } classifier_state_e;

endpackage

// File: rtl/snn_spike_counter.sv
// One per-neuron spike counter: synchronous clear, increment enable,
// saturates at all-ones instead of wrapping.
module snn_spike_counter
  import network_pkg::*;
#(
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  // Next count: clear wins over increment; hold once saturated.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/snn_spike_classifier.sv
// Counts output-neuron spikes over a programmable window of timesteps, then
// scans the counts one neuron per cycle to report the winning digit, its
// count and tie / no-spike flags.
module snn_spike_classifier
  import network_pkg::*;
#(
  parameter int WINDOW_WIDTH = DEFAULT_WINDOW_WIDTH,
  parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WINDOW_WIDTH-1:0]    window_len,
  input  logic                       step_valid,
  input  logic [OUTPUT_SIZE-1:0]     digit_spikes,
  output logic                       busy,
  output logic                       result_valid,
  output logic [CLASS_IDX_WIDTH-1:0] predicted_digit,
  output logic [COUNT_WIDTH-1:0]     max_count,
  output logic                       tie,
  output logic                       no_spike
);

  localparam logic [CLASS_IDX_WIDTH-1:0] LAST_IDX = CLASS_IDX_WIDTH'(OUTPUT_SIZE - 1);
  localparam logic [WINDOW_WIDTH-1:0]    ONE_STEP = WINDOW_WIDTH'(1);

  classifier_state_e state_q, state_d;

  logic [WINDOW_WIDTH-1:0]    len_q, len_d;
  logic [WINDOW_WIDTH-1:0]    step_q, step_d;
  logic [WINDOW_WIDTH-1:0]    step_next;
  logic [CLASS_IDX_WIDTH-1:0] scan_q, scan_d;
  logic [COUNT_WIDTH-1:0]     best_q, best_d;
  logic [CLASS_IDX_WIDTH-1:0] idx_q, idx_d;
  logic                       tie_scan_q, tie_scan_d;

  logic                       busy_q, busy_d;
  logic                       result_valid_q, result_valid_d;
  logic [CLASS_IDX_WIDTH-1:0] predicted_digit_q, predicted_digit_d;
  logic [COUNT_WIDTH-1:0]     max_count_q, max_count_d;
  logic                       tie_q, tie_d;
  logic                       no_spike_q, no_spike_d;

  logic [COUNT_WIDTH-1:0]     counts [OUTPUT_SIZE];
  logic [COUNT_WIDTH-1:0]     scan_count;
  logic                       clr_counts;
  logic [OUTPUT_SIZE-1:0]     inc_counts;

  // Counters clear on an accepted start and count only valid ACCUM steps.
  assign clr_counts = (state_q == IDLE) && start;
  assign inc_counts = ((state_q == ACCUM) && step_valid) ? digit_spikes : '0;

  for (genvar g = 0; g < OUTPUT_SIZE; g++) begin : g_counter
    snn_spike_counter #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_counter (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr_counts),
      .inc  (inc_counts[g]),
      .count(counts[g])
    );
  end

  assign scan_count = counts[scan_q];
  assign step_next  = step_q + ONE_STEP;

  // FSM next state: window accumulation, argmax scan and result capture.
  always_comb begin
    state_d           = state_q;
    len_d             = len_q;
    step_d            = step_q;
    scan_d            = scan_q;
    best_d            = best_q;
    idx_d             = idx_q;
    tie_scan_d        = tie_scan_q;
    busy_d            = busy_q;
    result_valid_d    = 1'b0;
    predicted_digit_d = predicted_digit_q;
    max_count_d       = max_count_q;
    tie_d             = tie_q;
    no_spike_d        = no_spike_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = ACCUM;
          busy_d  = 1'b1;
          step_d  = '0;
          // A zero-length window still consumes one timestep.
          len_d   = (window_len == '0) ? ONE_STEP : window_len;
        end
      end
      ACCUM: begin
        if (step_valid) begin
          step_d = step_next;
          if (step_next == len_q) begin
            state_d = ARGMAX;
            scan_d  = '0;
          end
        end
      end
      ARGMAX: begin
        // Strict greater-than keeps the lowest index on ties.
        if (scan_q == '0) begin
          best_d     = scan_count;
          idx_d      = '0;
          tie_scan_d = 1'b0;
        end else if (scan_count > best_q) begin
          best_d     = scan_count;
          idx_d      = scan_q;
          tie_scan_d = 1'b0;
        end else if (scan_count == best_q) begin
          tie_scan_d = 1'b1;
        end
        if (scan_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          scan_d = scan_q + CLASS_IDX_WIDTH'(1);
        end
      end
      DONE: begin
        predicted_digit_d = idx_q;
        max_count_d       = best_q;
        tie_d             = tie_scan_q;
        no_spike_d        = (best_q == '0);
        result_valid_d    = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, scan and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      len_q             <= '0;
      step_q            <= '0;
      scan_q            <= '0;
      best_q            <= '0;
      idx_q             <= '0;
      tie_scan_q        <= 1'b0;
      busy_q            <= 1'b0;
      result_valid_q    <= 1'b0;
      predicted_digit_q <= '0;
      max_count_q       <= '0;
      tie_q             <= 1'b0;
      no_spike_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      len_q             <= len_d;
      step_q            <= step_d;
      scan_q            <= scan_d;
      best_q            <= best_d;
      idx_q             <= idx_d;
      tie_scan_q        <= tie_scan_d;
      busy_q            <= busy_d;
      result_valid_q    <= result_valid_d;
      predicted_digit_q <= predicted_digit_d;
      max_count_q       <= max_count_d;
      tie_q             <= tie_d;
      no_spike_q        <= no_spike_d;
    end
  end

  assign busy            = busy_q;
  assign result_valid    = result_valid_q;
  assign predicted_digit = predicted_digit_q;
  assign max_count       = max_count_q;
  assign tie             = tie_q;
  assign no_spike        = no_spike_q;

endmodule

// File: tb/tb_snn_spike_classifier.sv
// Self-checking bench: two classifiers (8-bit and 4-bit counters) share one
// directed stimulus stream; a window-level model predicts every output cycle
// by cycle, and literal expectations pin the headline results.
module tb_snn_spike_classifier;

  localparam int NS  = network_pkg::OUTPUT_SIZE;
  localparam int IW  = network_pkg::CLASS_IDX_WIDTH;
  localparam int WW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [WW-1:0] window_len;
  logic          step_valid;
  logic [NS-1:0] digit_spikes;

  logic          busy0, rv0, tie0, ns0;
  logic [IW-1:0] pred0;
  logic [7:0]    max0;
  logic          busy1, rv1, tie1, ns1;
  logic [IW-1:0] pred1;
  logic [3:0]    max1;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  snn_spike_classifier #(.WINDOW_WIDTH(WW), .COUNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
    .step_valid(step_valid), .digit_spikes(digit_spikes),
    .busy(busy0), .result_valid(rv0), .predicted_digit(pred0),
    .max_count(max0), .tie(tie0), .no_spike(ns0)
  );

  snn_spike_classifier #(.WINDOW_WIDTH(WW), .COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
    .step_valid(step_valid), .digit_spikes(digit_spikes),
    .busy(busy1), .result_valid(rv1), .predicted_digit(pred1),
    .max_count(max1), .tie(tie1), .no_spike(ns1)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- window-level reference model ----------------
  int cyc = 0;
  int caps [2] = '{255, 15};
  bit m_active, m_accum, m_rv;
  int m_len, m_steps, m_done_at;
  int m_cnt   [2][NS];
  int r_pred  [2], r_max [2], r_tie [2];   // result computed at window end
  int e_pred  [2], e_max [2], e_tie [2], e_ns [2];  // visible outputs

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_active = 0; m_accum = 0; m_rv = 0; m_done_at = -10;
      for (int k = 0; k < 2; k++) begin
        e_pred[k] = 0; e_max[k] = 0; e_tie[k] = 0; e_ns[k] = 0;
      end
    end else begin
      m_rv = (cyc == m_done_at);
      if (cyc == m_done_at) begin
        for (int k = 0; k < 2; k++) begin
          e_pred[k] = r_pred[k]; e_max[k] = r_max[k];
          e_tie[k]  = r_tie[k];  e_ns[k]  = (r_max[k] == 0);
        end
      end
      if (cyc == m_done_at + 1) m_active = 0;
      if (!m_active && start) begin
        m_active = 1; m_accum = 1; m_steps = 0;
        m_len = (window_len == 0) ? 1 : int'(window_len);
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < NS; i++) m_cnt[k][i] = 0;
      end else if (m_accum && step_valid) begin
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < NS; i++)
            if (digit_spikes[i] && m_cnt[k][i] < caps[k]) m_cnt[k][i]++;
        m_steps++;
        if (m_steps == m_len) begin
          m_accum   = 0;
          m_done_at = cyc + NS + 1;
          for (int k = 0; k < 2; k++) begin
            int best, idx, n_eq;
            best = -1; idx = 0; n_eq = 0;
            for (int i = 0; i < NS; i++)
              if (m_cnt[k][i] > best) begin best = m_cnt[k][i]; idx = i; end
            for (int i = 0; i < NS; i++)
              if (m_cnt[k][i] == best) n_eq++;
            r_pred[k] = idx; r_max[k] = best; r_tie[k] = (n_eq > 1);
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("busy0", busy0, m_active);       check("busy1", busy1, m_active);
      check("rv0",   rv0,   m_rv);           check("rv1",   rv1,   m_rv);
      check("pred0", pred0, e_pred[0]);      check("pred1", pred1, e_pred[1]);
      check("max0",  max0,  e_max[0]);       check("max1",  max1,  e_max[1]);
      check("tie0",  tie0,  e_tie[0]);       check("tie1",  tie1,  e_tie[1]);
      check("nospk0", ns0,  e_ns[0]);        check("nospk1", ns1,  e_ns[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input int len);
    start = 1'b1; window_len = WW'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic step(input logic [NS-1:0] s);
    step_valid = 1'b1; digit_spikes = s;
    @(negedge clk);
    step_valid = 1'b0; digit_spikes = '0;
  endtask

  // Waits (bounded) until dut shows result_valid; returns at that negedge.
  task automatic wait_result(input string name);
    int n;
    n = 0;
    while (!rv0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " result_valid seen"}, rv0, 1);
  endtask

  localparam logic [NS-1:0] N1 = NS'(1);

  initial begin
    int lat, rv_cnt, got_pred, got_max;
    rst_n = 1'b0; start = 1'b0; window_len = '0;
    step_valid = 1'b0; digit_spikes = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("reset busy", busy0, 0);
    check("reset rv", rv0, 0);
    check("reset pred", pred0, 0);
    check("reset max", max0, 0);
    check("reset tie", tie0, 0);
    check("reset no_spike", ns0, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // 1: neuron 3 every step, window 5; latency 12 negedges after last drive
    do_start(5);
    repeat (5) step(N1 << 3);
    lat = 1;
    while (!rv0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t1 latency", lat, NS + 2);
    check("t1 pred", pred0, 3);
    check("t1 max", max0, 5);
    check("t1 tie", tie0, 0);
    check("t1 no_spike", ns0, 0);
    @(negedge clk);
    check("t1 rv one cycle", rv0, 0);

    // 2: neurons 2 and 7 x4, neuron 5 x3 -> lowest index wins the tie
    do_start(6);
    repeat (3) step((N1 << 2) | (N1 << 7) | (N1 << 5));
    step((N1 << 2) | (N1 << 7));
    step('0);
    step('0);
    wait_result("t2");
    check("t2 pred", pred0, 2);
    check("t2 max", max0, 4);
    check("t2 tie", tie0, 1);
    check("t2 no_spike", ns0, 0);

    // 3: back-to-back start in the result_valid cycle; all silent
    do_start(8);
    repeat (8) step('0);
    wait_result("t3");
    check("t3 pred", pred0, 0);
    check("t3 max", max0, 0);
    check("t3 no_spike", ns0, 1);
    check("t3 tie", tie0, 1);

    // 4: neuron 9 for 20 steps; 4-bit counters saturate at 15
    do_start(20);
    repeat (20) step(N1 << 9);
    wait_result("t4");
    check("t4 max 8bit", max0, 20);
    check("t4 max sat", max1, 15);
    check("t4 pred sat", pred1, 9);
    check("t4 tie sat", tie1, 0);
    @(negedge clk);

    // 5: window_len=0, stray start in an ACCUM gap, steps 1,0,0,1
    do_start(0);
    start = 1'b1; window_len = WW'(3);
    @(negedge clk);
    start = 1'b0;
    step(N1 << 4);
    repeat (2) @(negedge clk);
    step(N1 << 6);
    rv_cnt = 0; got_pred = -1; got_max = -1;
    repeat (30) begin
      if (rv0) begin
        rv_cnt++;
        got_pred = pred0;
        got_max  = max0;
      end
      @(negedge clk);
    end
    check("t5 result count", rv_cnt, 1);
    check("t5 pred", got_pred, 4);
    check("t5 max", got_max, 1);

    // 6: reset 3 steps into a 5-step window, then a clean 2-step window
    do_start(5);
    repeat (3) step(N1 << 0);
    rst_n = 1'b0;
    #1;
    check("t6 rst busy", busy0, 0);
    check("t6 rst rv", rv0, 0);
    check("t6 rst pred", pred0, 0);
    check("t6 rst max", max0, 0);
    check("t6 rst tie", tie0, 0);
    check("t6 rst no_spike", ns0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rv_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (rv0) rv_cnt++;
    end
    check("t6 no result after abort", rv_cnt, 0);
    do_start(2);
    repeat (2) step(N1 << 1);
    wait_result("t6");
    check("t6 pred", pred0, 1);
    check("t6 max", max0, 2);
    check("t6 tie", tie0, 0);
    repeat (3) @(negedge clk);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snn_spike_classifier.md
Name: snn_spike_classifier

Overview:
Downstream stage of the SNN network core. Consumes the per-timestep output digit_spikes vector and counts spikes per output neuron over a programmable window of timesteps. It then runs a sequential argmax over the counts and reports the predicted digit with its spike count and tie/no-spike flags. Its result feeds the scoreboard-visible classification output.

Parameters:
OUTPUT_SIZE, 10, number of output neurons (digit classes); taken from network_pkg
WINDOW_WIDTH, 8, width of the timestep window length and step counter
COUNT_WIDTH, 8, width of each per-neuron saturating spike counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a classification window (accepted only in IDLE)
window_len  input  WINDOW_WIDTH  timesteps per window, latched on accepted start; 0 treated as 1
step_valid  input  1  digit_spikes holds one valid timestep this cycle
digit_spikes  input  OUTPUT_SIZE  one spike bit per output neuron, bit i = neuron i
busy  output  1  high from accepted start until result_valid cycle inclusive
result_valid  output  1  one-cycle pulse; result outputs valid
predicted_digit  output  CLASS_IDX_WIDTH  index of the neuron with the highest count
max_count  output  COUNT_WIDTH  spike count of predicted_digit
tie  output  1  at least one other neuron equals max_count
no_spike  output  1  max_count == 0, i.e. no output spikes in the window

Behaviour:
- Reset: clk and rst_n (asynchronous, active-low) as fixed. Asserting rst_n low forces state IDLE, all counters and step counter to 0, and busy, result_valid, predicted_digit, max_count, tie, no_spike to 0. Reset mid-window aborts it with no result_valid.
- FSM states: IDLE, ACCUM, ARGMAX, DONE.
- IDLE: start=1 -> clear all spike counters and step counter, latch max(window_len,1), go ACCUM, busy=1. Result outputs hold previous values until overwritten in DONE.
- ACCUM: each cycle with step_valid=1: counter[i] += digit_spikes[i] for all i, saturating at 2^COUNT_WIDTH-1. Step counter +1. When the incremented step count equals the latched length, go ARGMAX. step_valid=0 cycles are gaps; nothing changes.
- start is ignored outside IDLE. step_valid is ignored outside ACCUM.
- ARGMAX runs exactly OUTPUT_SIZE cycles, scanning index 0..OUTPUT_SIZE-1, one per cycle:
  - index 0 loads best=count[0], idx=0, tie=0.
  - For index i>0: count[i] > best -> best=count[i], idx=i, tie=0; count[i] == best -> tie=1.
  - Lowest index wins ties.
- DONE: registered outputs update. predicted_digit=idx, max_count=best, tie, no_spike=(best==0). result_valid=1 for exactly one cycle, then IDLE. busy falls in the cycle after DONE.
- Latency: final step_valid sampled at edge E -> result_valid high in the cycle after edge E+OUTPUT_SIZE+1.
- Back-to-back: a start arriving the cycle after DONE is accepted.

Decomposition:
- network_pkg gains:
  - CLASS_IDX_WIDTH = $clog2(OUTPUT_SIZE)
  - typedef enum classifier_state_e {IDLE, ACCUM, ARGMAX, DONE}
  - default COUNT_WIDTH and WINDOW_WIDTH constants
- Sub-module snn_spike_counter: one COUNT_WIDTH saturating counter with sync clear and increment enable, instantiated OUTPUT_SIZE times via generate.
- FSM, step counter and argmax scan stay in the top module.

Test Plan:
1. window_len=5; neuron 3 spikes every step, others 0 -> predicted_digit=3, max_count=5, tie=0, no_spike=0; result_valid is one cycle, OUTPUT_SIZE+1 edges after the 5th step.
2. window_len=6; neurons 2 and 7 spike 4 times each, neuron 5 spikes 3 times -> predicted_digit=2, max_count=4, tie=1.
3. window_len=8, all digit_spikes=0 -> predicted_digit=0, max_count=0, no_spike=1, tie=1.
4. COUNT_WIDTH=4, window_len=20, neuron 9 spikes every step -> max_count=15 (saturated), predicted_digit=9, tie=0.
5. window_len=0 with step_valid gaps (1,0,0,1) and a start pulse during ACCUM -> window ends after the first valid step; the extra start is ignored; exactly one result_valid.
6. rst_n low mid-ACCUM (3 of 5 steps) -> all outputs 0, no result_valid; a following start with window_len=2 and neuron 1 spiking gives predicted_digit=1, max_count=2.
